// File: rtl/seq_detector_prog.sv
// Programmable serial pattern detector: loadable pattern, length and overlap mode.
// Optional saturating match counter enabled by defining SEQDET_MATCH_CNT_EN.
module seq_detector_prog #(
    parameter int unsigned PAT_W = 8,
    parameter int unsigned LEN_W = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_overlap,
    input  logic             cnt_clr,
    output logic             detected,
    output logic             cfg_err,
    output logic             armed,
    output logic [CNT_W-1:0] match_count
);

    typedef enum logic [1:0] {
        UNCFG = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [PAT_W-1:0] hist_q, hist_d;
    logic [LEN_W-1:0] hist_cnt_q, hist_cnt_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             ovl_q, ovl_d;
    logic             det_q, det_d;
    logic             err_q, err_d;
    logic             armed_q, armed_d;

    logic [PAT_W-1:0] mask;
    logic [PAT_W-1:0] shifted;
    logic [LEN_W-1:0] cnt_inc;
    logic             accept;
    logic             legal;
    logic             hit;
    logic             unused_hist_msb;

    // Only the low len bits of history and pattern take part in the compare.
    assign mask    = {PAT_W{1'b1}} >> (LEN_W'(PAT_W) - len_q);
    assign shifted = {hist_q[PAT_W-2:0], in_bit};
    assign cnt_inc = (hist_cnt_q == len_q) ? hist_cnt_q : hist_cnt_q + LEN_W'(1);
    assign accept  = in_valid && !cfg_load && (state_q != UNCFG);
    assign legal   = (cfg_len != '0) && (cfg_len <= LEN_W'(PAT_W));
    assign hit     = accept && (cnt_inc >= len_q) && (((shifted ^ pat_q) & mask) == '0);
    assign unused_hist_msb = hist_q[PAT_W-1];

    // Next-state and output decode.
    always_comb begin
        state_d    = state_q;
        hist_d     = hist_q;
        hist_cnt_d = hist_cnt_q;
        pat_d      = pat_q;
        len_d      = len_q;
        ovl_d      = ovl_q;
        err_d      = err_q;
        armed_d    = armed_q;
        det_d      = 1'b0;

        if (cfg_load) begin
            if (legal) begin
                pat_d      = cfg_pattern;
                len_d      = cfg_len;
                ovl_d      = cfg_overlap;
                hist_d     = '0;
                hist_cnt_d = '0;
                err_d      = 1'b0;
                armed_d    = 1'b1;
                state_d    = FILL;
            end else begin
                err_d = 1'b1;
            end
        end else if (accept) begin
            hist_d     = shifted;
            hist_cnt_d = cnt_inc;
            det_d      = hit;
            case (state_q)
                FILL: begin
                    if (hit && !ovl_q) begin
                        hist_cnt_d = '0;
                    end else if (cnt_inc == len_q) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (hit && !ovl_q) begin
                        hist_cnt_d = '0;
                        state_d    = FILL;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= UNCFG;
            hist_q     <= '0;
            hist_cnt_q <= '0;
            pat_q      <= '0;
            len_q      <= '0;
            ovl_q      <= 1'b0;
            det_q      <= 1'b0;
            err_q      <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            hist_q     <= hist_d;
            hist_cnt_q <= hist_cnt_d;
            pat_q      <= pat_d;
            len_q      <= len_d;
            ovl_q      <= ovl_d;
            det_q      <= det_d;
            err_q      <= err_d;
            armed_q    <= armed_d;
        end
    end

    assign detected = det_q;
    assign cfg_err  = err_q;
    assign armed    = armed_q;

`ifdef SEQDET_MATCH_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    // Clear takes priority over a coincident match; count saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (cnt_clr) begin
            cnt_q <= '0;
        end else if (det_d && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign match_count = cnt_q;
`else
    logic unused_cnt_clr;

    assign unused_cnt_clr = cnt_clr;
    assign match_count    = '0;
`endif

endmodule

// File: tb/tb_seq_detector_prog.sv
// Self-checking bench for seq_detector_prog: queue-based stream model plus directed scenarios.
module tb_seq_detector_prog;

    localparam int PAT_W = 8;
    localparam int LEN_W = 4;
    localparam int CNT_W = 2;
    localparam int CNT_MAX = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_bit = 1'b0;
    logic             cfg_load = 1'b0;
    logic [PAT_W-1:0] cfg_pattern = '0;
    logic [LEN_W-1:0] cfg_len = '0;
    logic             cfg_overlap = 1'b0;
    logic             cnt_clr = 1'b0;
    logic             detected;
    logic             cfg_err;
    logic             armed;
    logic [CNT_W-1:0] match_count;

    seq_detector_prog #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr), .detected(detected),
        .cfg_err(cfg_err), .armed(armed), .match_count(match_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: configuration plus the list of accepted bits since the last restart.
    bit             m_armed = 1'b0;
    bit             m_err   = 1'b0;
    bit             m_ovl   = 1'b0;
    bit             m_det   = 1'b0;
    logic [PAT_W-1:0] m_pat = '0;
    int             m_len   = 0;
    int             m_cnt   = 0;
    bit             hist[$];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_armed = 1'b0; m_err = 1'b0; m_ovl = 1'b0; m_det = 1'b0;
        m_pat = '0; m_len = 0; m_cnt = 0;
        hist.delete();
    endtask

    task automatic model_step(input bit ld, input logic [PAT_W-1:0] p, input int l,
                              input bit o, input bit v, input bit b, input bit clr);
        bit hit;
        hit = 1'b0;
        if (ld) begin
            if (l >= 1 && l <= PAT_W) begin
                m_armed = 1'b1; m_pat = p; m_len = l; m_ovl = o; m_err = 1'b0;
                hist.delete();
            end else begin
                m_err = 1'b1;
            end
        end else if (v && m_armed) begin
            hist.push_back(b);
            if (hist.size() > m_len) void'(hist.pop_front());
            if (hist.size() == m_len) begin
                hit = 1'b1;
                for (int i = 0; i < m_len; i++)
                    if (hist[i] != m_pat[m_len-1-i]) hit = 1'b0;
            end
            if (hit && !m_ovl) hist.delete();
        end
        m_det = hit;
`ifdef SEQDET_MATCH_CNT_EN
        if (clr) m_cnt = 0;
        else if (hit && m_cnt < CNT_MAX) m_cnt++;
`else
        if (clr) m_cnt = 0;
`endif
    endtask

    // Per-cycle compare of every output against the model.
    initial begin
        forever begin
            @(negedge clk);
            check("detected", int'(detected), int'(m_det));
            check("cfg_err", int'(cfg_err), int'(m_err));
            check("armed", int'(armed), int'(m_armed));
            check("match_count", int'(match_count), m_cnt);
        end
    end

    task automatic step(input bit v, input bit b, input bit ld, input logic [PAT_W-1:0] p,
                        input int l, input bit o, input bit clr);
        in_valid = v; in_bit = b; cfg_load = ld; cfg_pattern = p;
        cfg_len = LEN_W'(l); cfg_overlap = o; cnt_clr = clr;
        model_step(ld, p, l, o, v, b, clr);
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, '0, 0, 1'b0, 1'b0);
    endtask

    task automatic load(input logic [PAT_W-1:0] p, input int l, input bit o);
        step(1'b0, 1'b0, 1'b1, p, l, o, 1'b0);
    endtask

    task automatic send_seq(input logic [31:0] bits, input int n, input bit gap,
                            output logic [31:0] pulses);
        pulses = '0;
        for (int i = n - 1; i >= 0; i--) begin
            step(1'b1, bits[i], 1'b0, '0, 0, 1'b0, 1'b0);
            pulses = {pulses[30:0], detected};
            if (gap) begin
                idle();
                idle();
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    logic [31:0] pulses;

    initial begin
        #1;
        do_reset();
        check("reset_armed", int'(armed), 0);

        // Bits while unconfigured are discarded.
        send_seq(32'b1011, 4, 1'b0, pulses);
        check("uncfg_pulses", int'(pulses), 0);

        // Overlapping 1011 in 1011011.
        load(8'b1011, 4, 1'b1);
        check("load_armed", int'(armed), 1);
        send_seq(32'b1011011, 7, 1'b0, pulses);
        check("ovl_pulses", int'(pulses), 7'b0001001);
`ifdef SEQDET_MATCH_CNT_EN
        check("ovl_count", int'(match_count), 2);
`else
        check("ovl_count", int'(match_count), 0);
`endif

        // Non-overlapping, counter cleared alongside the load.
        step(1'b0, 1'b0, 1'b1, 8'b1011, 4, 1'b0, 1'b1);
        send_seq(32'b1011011, 7, 1'b0, pulses);
        check("novl_pulses", int'(pulses), 7'b0001000);
`ifdef SEQDET_MATCH_CNT_EN
        check("novl_count", int'(match_count), 1);
`else
        check("novl_count", int'(match_count), 0);
`endif

        // Illegal load while armed keeps the old configuration and history.
        load(8'hFF, 0, 1'b1);
        check("ill_err_armed", int'(cfg_err), 1);
        check("ill_keeps_armed", int'(armed), 1);
        send_seq(32'b1011, 4, 1'b0, pulses);
        check("ill_old_cfg", int'(pulses), 4'b0001);
        load(8'hFF, PAT_W + 1, 1'b1);
        check("ill_err_len9", int'(cfg_err), 1);
        load(8'b1011, 4, 1'b1);
        check("legal_clr_err", int'(cfg_err), 0);

        // Illegal loads from unconfigured.
        do_reset();
        load(8'h01, 0, 1'b0);
        check("uncfg_err0", int'(cfg_err), 1);
        load(8'h01, PAT_W + 1, 1'b0);
        check("uncfg_err9", int'(cfg_err), 1);
        check("uncfg_armed", int'(armed), 0);
        send_seq(32'b1111, 4, 1'b0, pulses);
        check("uncfg_no_det", int'(pulses), 0);

        // Length 1, counter saturation and clear coincident with a match.
        load(8'h01, 1, 1'b0);
        check("len1_err_clr", int'(cfg_err), 0);
        send_seq(32'b111111, 6, 1'b0, pulses);
        check("len1_pulses", int'(pulses), 6'b111111);
`ifdef SEQDET_MATCH_CNT_EN
        check("len1_sat", int'(match_count), 3);
`else
        check("len1_sat", int'(match_count), 0);
`endif
        step(1'b1, 1'b1, 1'b0, '0, 0, 1'b0, 1'b1);
        check("clr_hit_det", int'(detected), 1);
        check("clr_hit_cnt", int'(match_count), 0);
        send_seq(32'b0, 1, 1'b0, pulses);
        check("len1_zero", int'(pulses), 0);

        // Full-width pattern with gaps in in_valid.
        load(8'hA5, PAT_W, 1'b1);
        send_seq(32'hA5, 8, 1'b1, pulses);
        check("gap_pulses", int'(pulses), 8'b00000001);

        // Reset mid-match aborts it.
        load(8'b1011, 4, 1'b1);
        send_seq(32'b101, 3, 1'b0, pulses);
        do_reset();
        send_seq(32'b1, 1, 1'b0, pulses);
        check("rst_no_pulse", int'(pulses), 0);
        check("rst_armed", int'(armed), 0);

        // Load coincident with the final matching bit restarts history.
        load(8'b1011, 4, 1'b1);
        send_seq(32'b101, 3, 1'b0, pulses);
        step(1'b1, 1'b1, 1'b1, 8'b1011, 4, 1'b1, 1'b0);
        check("coinc_no_det", int'(detected), 0);
        send_seq(32'b1011, 4, 1'b0, pulses);
        check("coinc_restart", int'(pulses), 4'b0001);

        idle();
        idle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_detector_prog.md
SEQ_DETECTOR_PROG -- requirements
Module: seq_detector_prog

Interface
REQ-001 Parameter PAT_W, default 8, SHALL set the maximum pattern length in bits (legal 2..32).
REQ-002 Parameter LEN_W, default 4, SHALL set the width of cfg_len and SHALL satisfy 2^LEN_W > PAT_W.
REQ-003 Parameter CNT_W, default 8, SHALL set the width of match_count.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 in_valid  input  1  SHALL qualify in_bit; in_bit is ignored when low.
REQ-007 in_bit  input  1  SHALL be the serial data bit.
REQ-008 cfg_load  input  1  SHALL load cfg_pattern, cfg_len and cfg_overlap on the same clk edge.
REQ-009 cfg_pattern  input  PAT_W  SHALL carry the pattern, right-aligned; bit [len-1] is matched first and bit [0] last.
REQ-010 cfg_len  input  LEN_W  SHALL carry the pattern length.
REQ-011 cfg_overlap  input  1  SHALL select overlapping detection when 1 and non-overlapping detection when 0.
REQ-012 cnt_clr  input  1  SHALL synchronously clear match_count.
REQ-013 detected  output  1  SHALL be a registered one-cycle match pulse.
REQ-014 cfg_err  output  1  SHALL be a sticky flag indicating that an illegal length was loaded.
REQ-015 armed  output  1  SHALL be high when a valid configuration is held.
REQ-016 match_count  output  CNT_W  SHALL be a registered match counter.

Function
REQ-017 FSM states SHALL be UNCFG, FILL and RUN.
- UNCFG -> FILL on a cfg_load with a legal length.
- FILL -> RUN when hist_cnt reaches len.
- RUN -> FILL on a match in non-overlap mode.
REQ-018 A cfg_len of 1..PAT_W SHALL be legal; any other value SHALL leave all state unchanged and set cfg_err.
REQ-019 A legal cfg_load SHALL clear the history register and hist_cnt, clear cfg_err, and enter FILL.
REQ-020 Each accepted bit (in_valid=1) SHALL shift into the history register; hist_cnt SHALL increment and saturate at len.
REQ-021 A match SHALL be declared when hist_cnt >= len after the shift and the newest len history bits equal cfg_pattern[len-1:0].
REQ-022 detected SHALL be high for exactly the one cycle following the edge that accepted the final matching bit; latency is 1 clk.
REQ-023 In overlap mode, hist_cnt SHALL be retained after a match; for example, 1011 in the stream 1011011 SHALL match twice.
REQ-024 In non-overlap mode, hist_cnt SHALL clear to 0 on a match; for example, 1011 in the stream 1011011 SHALL match once.
REQ-025 Bits arriving in UNCFG SHALL be discarded and SHALL never produce detected.
REQ-026 When cfg_load and in_valid coincide, cfg_load SHALL win and the bit SHALL be discarded.
REQ-027 match_count SHALL increment once per match and saturate at 2^CNT_W-1 without wrapping.
REQ-028 When cnt_clr and a match coincide, match_count SHALL become 0; the match SHALL still pulse detected.
REQ-029 A gap in in_valid SHALL not break a match in progress; only accepted bits count.

Reset
REQ-030 On assertion of rst_n=0, state SHALL immediately become UNCFG and all outputs (detected, cfg_err, armed, match_count) SHALL be 0.
REQ-031 On assertion of rst_n=0, history, hist_cnt, the stored pattern, stored length and stored overlap SHALL be 0.
REQ-032 Reset asserted mid-match SHALL abort the match with no detected pulse, and a new cfg_load SHALL be required after release.
REQ-033 The first clk edge after rst_n deasserts SHALL be treated as normal operation.

Configuration
REQ-034 Macro SEQDET_MATCH_CNT_EN SHALL control the match counter.
- When defined: the match counter SHALL be implemented per REQ-027/028.
- When undefined: no counter flops SHALL exist, match_count SHALL be tied to 0, and cnt_clr SHALL be ignored.
- All other behaviour SHALL be identical in both builds.

Verification
REQ-035 Scenario: load pattern=1011, len=4, overlap=1; drive stream 1011011 -> detected pulses after bit 4 and bit 7; match_count=2.
REQ-036 Scenario: same stream with overlap=0 -> a single pulse after bit 4; match_count=1.
REQ-037 Scenario: load len=0 and then len=PAT_W+1 -> cfg_err=1, armed unchanged, and no detections follow; a subsequent legal load clears cfg_err.
REQ-038 Scenario: len=1, pattern=1, CNT_W=2; drive six 1s -> six pulses and match_count saturates at 3; cnt_clr drives it to 0.
REQ-039 Scenario: assert rst_n low after bits 101 of 1011, release, and send the final 1 -> no pulse and armed=0.
REQ-040 Scenario: apply cfg_load coincident with the final bit of a match -> no pulse, and the history restarts from empty.
